// File: rtl/nspi_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : nspi_frame_scheduler_if
//  Description : Frame-buffer read port and nspi_tx handshake bundle used by
//                nspi_frame_scheduler. master = scheduler side, slave = the
//                buffer / transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nspi_frame_scheduler_if #(
    parameter int CHANNEL_NUMBER  = 3,
    parameter int SPI_SIZE        = 8,
    parameter int WORDS_PER_FRAME = 128
);
    localparam int ADDR_W = $clog2(WORDS_PER_FRAME);
    localparam int DATA_W = CHANNEL_NUMBER * SPI_SIZE;

    // Frame buffer synchronous read port
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // nspi_tx load/start/finish handshake
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_finish;

    modport master (
        output rd_en, rd_addr, tx_data, tx_start,
        input  rd_data, tx_finish
    );

    modport slave (
        input  rd_en, rd_addr, tx_data, tx_start,
        output rd_data, tx_finish
    );
endinterface
`default_nettype wire

// File: rtl/nspi_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : nspi_frame_scheduler
//  Description : Walks one nspi_tx instance through a full LED-matrix frame:
//                fetch word, load, pulse start, wait for the finish handshake,
//                repeat for WORDS_PER_FRAME words. Queues one extra frame
//                request, flags overrun and handshake timeouts.
//  Options     : NSPI_SCHED_LATCH_EN - adds a LATCH state driving a row latch
//                pulse of LATCH_CYCLES cycles after the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module nspi_frame_scheduler #(
    parameter int CHANNEL_NUMBER  = 3,
    parameter int SPI_SIZE        = 8,
    parameter int WORDS_PER_FRAME = 128,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int LATCH_CYCLES    = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    frame_start_i,
    input  wire                    err_clr_i,
    nspi_frame_scheduler_if.master bus,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   overrun_o,
    output logic                   timeout_err_o,
    output logic                   latch_o
);
    localparam int ADDR_W  = $clog2(WORDS_PER_FRAME);
    localparam int DATA_W  = CHANNEL_NUMBER * SPI_SIZE;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > LATCH_CYCLES) ? TIMEOUT_CYCLES : LATCH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef NSPI_SCHED_LATCH_EN
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LOAD      = 3'd2,
        S_START     = 3'd3,
        S_WAIT_BUSY = 3'd4,
        S_WAIT_DONE = 3'd5
`ifdef NSPI_SCHED_LATCH_EN
        ,
        S_LATCH     = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;      // handshake timeout / latch width counter
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    // Sequencer next-state, frame queueing and sticky error flags
    always_comb begin
        logic ovr_evt;
        logic tmo_evt;
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        ovr_evt   = 1'b0;
        tmo_evt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request arriving with one already queued collapses into a single frame
                if (frame_start_i || pend_q) begin
                    state_d = S_FETCH;
                    word_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                tx_data_d = bus.rd_data;
                state_d   = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.tx_finish) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus.tx_finish) begin
                    if (word_q != LAST_WORD) begin
                        word_d  = word_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else begin
`ifdef NSPI_SCHED_LATCH_EN
                        cnt_d   = '0;
                        state_d = S_LATCH;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end else if (cnt_q == TMO_LAST) begin
                    tmo_evt = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef NSPI_SCHED_LATCH_EN
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Requests while busy: first one is queued, any further one is an overrun
        if (state_q != S_IDLE && frame_start_i) begin
            if (!pend_q) pend_d  = 1'b1;
            else         ovr_evt = 1'b1;
        end

        // A new error event beats a simultaneous clear
        overrun_d = ovr_evt ? 1'b1 : (err_clr_i ? 1'b0 : overrun_q);
        timeout_d = tmo_evt ? 1'b1 : (err_clr_i ? 1'b0 : timeout_q);
    end

    // State and datapath registers; reset aborts any frame immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.rd_en    = (state_q == S_FETCH);
    assign bus.rd_addr  = word_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = (state_q == S_START);
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = done_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_q;
`ifdef NSPI_SCHED_LATCH_EN
    assign latch_o       = (state_q == S_LATCH);
`else
    assign latch_o       = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_nspi_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nspi_frame_scheduler
//  Description : Self-checking bench for nspi_frame_scheduler with a frame
//                buffer model, an nspi_tx handshake model and a frame-level
//                scoreboard (expected word order and data per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nspi_frame_scheduler;
    localparam int CH    = 3;
    localparam int SZ    = 8;
    localparam int WORDS = 128;
    localparam int TMO   = 64;
    localparam int LAT   = 4;
    localparam int DW    = CH * SZ;

    localparam int M_NORMAL     = 0;
    localparam int M_STUCK_IDLE = 1;
    localparam int M_STUCK_BUSY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic err_clr = 1'b0;
    logic busy, frame_done, overrun, timeout_err, latch;

    nspi_frame_scheduler_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .WORDS_PER_FRAME(WORDS)) bif ();

    nspi_frame_scheduler #(
        .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .WORDS_PER_FRAME(WORDS),
        .TIMEOUT_CYCLES(TMO), .LATCH_CYCLES(LAT)
    ) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start), .err_clr_i(err_clr),
        .bus(bif), .busy_o(busy), .frame_done_o(frame_done), .overrun_o(overrun),
        .timeout_err_o(timeout_err), .latch_o(latch)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- environment models ----------------
    logic [DW-1:0] mem [WORDS];
    int mode    = M_NORMAL;
    int dur_cfg = 10;      // 0 = random transmit length per word
    int tx_left = 0;

    always @(posedge clk)
        if (bif.rd_en) bif.rd_data <= mem[bif.rd_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bif.tx_finish <= 1'b1;
            tx_left       <= 0;
        end else if (bif.tx_start && mode != M_STUCK_IDLE) begin
            bif.tx_finish <= 1'b0;
            tx_left       <= (dur_cfg == 0) ? int'($urandom_range(15, 1)) : dur_cfg;
        end else if (tx_left > 1) begin
            tx_left <= tx_left - 1;
        end else if (mode != M_STUCK_BUSY) begin
            tx_left       <= 0;
            bif.tx_finish <= 1'b1;
        end
    end

    // ---------------- frame scoreboard ----------------
    int word_idx = 0;   // index of the word the current frame should be on
    int starts = 0, addr_bad = 0, data_bad = 0, dones = 0, done_bad = 0;
    int dones_total = 0, lat_run = 0, lat_runs = 0, lat_bad = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bif.rd_en && int'(bif.rd_addr) != word_idx) addr_bad++;
            if (bif.tx_start) begin
                if (word_idx >= WORDS || bif.tx_data !== mem[word_idx]) data_bad++;
                starts++;
                word_idx++;
            end
            if (frame_done) begin
                dones++;
                dones_total++;
                if (busy || word_idx != WORDS) done_bad++;
            end
`ifdef NSPI_SCHED_LATCH_EN
            if (latch) begin
                if (lat_run == 0 && word_idx != WORDS) lat_bad++;
                lat_run++;
            end else begin
                if (lat_run > 0) begin
                    lat_runs++;
                    if (lat_run != LAT || !frame_done) lat_bad++;
                end else if (frame_done) begin
                    lat_bad++;
                end
                lat_run = 0;
            end
`else
            if (latch) lat_bad++;
`endif
            if (!busy) word_idx = 0;
        end else begin
            word_idx = 0;
        end
    end

    task automatic clear_sb();
        starts = 0; addr_bad = 0; data_bad = 0; dones = 0; done_bad = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c = 0;
        while (!(dones >= n && !busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (dones >= n && !busy);
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        int dur;       // transmit length, 0 = random
        int extra;     // additional frame_start pulses during the first frame
        int frames;    // frames expected to complete
        bit ovr;       // expected overrun flag
        bit pat;       // 1 = {addr,addr,addr} data, 0 = random data
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int n;
        logic [DW-1:0] held;

        vecs[0] = '{dur: 10, extra: 0, frames: 1, ovr: 1'b0, pat: 1'b1};
        vecs[1] = '{dur: 1,  extra: 0, frames: 1, ovr: 1'b0, pat: 1'b0};
        vecs[2] = '{dur: 0,  extra: 1, frames: 2, ovr: 1'b0, pat: 1'b0};
        vecs[3] = '{dur: 10, extra: 2, frames: 2, ovr: 1'b1, pat: 1'b1};
        vecs[4] = '{dur: 0,  extra: 3, frames: 2, ovr: 1'b1, pat: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, frame_done, overrun, timeout_err, latch,
                              bif.rd_en, bif.tx_start, bif.rd_addr, bif.tx_data}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven full frames
        for (int i = 0; i < 5; i++) begin
            for (int a = 0; a < WORDS; a++)
                mem[a] = vecs[i].pat ? {CH{SZ'(a)}} : DW'($urandom);
            dur_cfg = vecs[i].dur;
            mode    = M_NORMAL;
            pulse_clr();
            @(negedge clk);
            chk($sformatf("v%0d_overrun_cleared", i), overrun, 1'b0);
            clear_sb();
            pulse_start();
            for (int e = 0; e < vecs[i].extra; e++) begin
                repeat ($urandom_range(60, 5)) @(posedge clk);
                pulse_start();
            end
            wait_frames(vecs[i].frames, 20000, ok);
            chk($sformatf("v%0d_completed", i), ok, 1'b1);
            chk($sformatf("v%0d_tx_starts", i), starts, WORDS * vecs[i].frames);
            chk($sformatf("v%0d_rd_addr_seq", i), addr_bad, 0);
            chk($sformatf("v%0d_tx_data", i), data_bad, 0);
            chk($sformatf("v%0d_frame_done_cnt", i), dones, vecs[i].frames);
            chk($sformatf("v%0d_frame_done_pos", i), done_bad, 0);
            chk($sformatf("v%0d_overrun", i), overrun, vecs[i].ovr);
        end

        // Queueing, err_clr priority, request coincident with pending in IDLE
        dur_cfg = 4;
        pulse_clr();
        clear_sb();
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        @(negedge clk);
        chk("hs_pending_no_overrun", overrun, 1'b0);
        pulse_start();
        @(negedge clk);
        chk("hs_third_sets_overrun", overrun, 1'b1);
        pulse_clr();
        @(negedge clk);
        chk("hs_err_clr", overrun, 1'b0);
        chk("hs_err_clr_keeps_busy", busy, 1'b1);
        n = 0;
        while (!frame_done && n < 5000) begin @(negedge clk); n++; end
        chk("hs_first_frame_done", frame_done, 1'b1);
        frame_start = 1'b1;                 // lands on the IDLE cycle with pending set
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        chk("hs_idle_merge_no_overrun", overrun, 1'b0);
        chk("hs_idle_merge_busy", busy, 1'b1);
        repeat (30) @(posedge clk);
        pulse_start();                      // queued again
        @(posedge clk); #1 begin frame_start = 1'b1; err_clr = 1'b1; end
        @(posedge clk); #1 begin frame_start = 1'b0; err_clr = 1'b0; end
        @(negedge clk);
        chk("hs_set_wins_over_clr", overrun, 1'b1);
        wait_frames(3, 20000, ok);
        chk("hs_completed", ok, 1'b1);
        chk("hs_frame_cnt", dones, 3);
        chk("hs_tx_starts", starts, 3 * WORDS);
        chk("hs_rd_addr_seq", addr_bad, 0);

        // Timeout waiting for nspi_tx to go busy
        pulse_clr();
        mode = M_STUCK_IDLE;
        clear_sb();
        pulse_start();
        n = 0;
        while (!bif.tx_start && n < 100) begin @(negedge clk); n++; end
        chk("to1_start_seen", bif.tx_start, 1'b1);
        held = bif.tx_data;
        n = 0;
        while (!timeout_err && n < 300) begin @(negedge clk); n++; end
        chk("to1_latency_64", (n >= TMO && n <= TMO + 1), 1'b1);
        chk("to1_not_busy", busy, 1'b0);
        chk("to1_tx_data_held", bif.tx_data, held);
        repeat (10) @(negedge clk);
        chk("to1_sticky", timeout_err, 1'b1);
        chk("to1_no_frame_done", dones, 0);
        chk("to1_single_start", starts, 1);
        pulse_clr();
        @(negedge clk);
        chk("to1_err_clr", timeout_err, 1'b0);

        // Timeout waiting for nspi_tx to finish; queued frame then runs
        mode = M_STUCK_BUSY;
        clear_sb();
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_start();
        n = 0;
        while (!timeout_err && n < 500) begin @(negedge clk); n++; end
        chk("to2_timeout", timeout_err, 1'b1);
        chk("to2_no_frame_done", dones, 0);
        mode = M_NORMAL;
        dur_cfg = 3;
        clear_sb();
        wait_frames(1, 20000, ok);
        chk("to2_pending_frame_ran", ok && dones == 1, 1'b1);
        chk("to2_pending_starts", starts, WORDS);
        chk("to2_pending_addr_seq", addr_bad, 0);

        // Reset mid-frame at word 50 (timeout_err is still set from above)
        dur_cfg = 10;
        clear_sb();
        pulse_start();
        pulse_start();
        pulse_start();
        n = 0;
        while (starts < 50 && n < 5000) begin @(negedge clk); n++; end
        chk("rst_reached_word50", starts, 50);
        #2 rst = 1'b1;
        #1 chk("rst_mid_frame_outputs", {busy, frame_done, overrun, timeout_err, latch,
                                         bif.rd_en, bif.tx_start, bif.rd_addr, bif.tx_data}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pending_dropped", busy, 1'b0);
        clear_sb();
        pulse_start();
        wait_frames(1, 20000, ok);
        chk("rst_restart_done", ok, 1'b1);
        chk("rst_restart_addr_seq", addr_bad, 0);
        chk("rst_restart_starts", starts, WORDS);
        chk("rst_restart_data", data_bad, 0);

        // Latch pulse placement over every frame run
`ifdef NSPI_SCHED_LATCH_EN
        chk("latch_per_frame", lat_runs, dones_total);
`endif
        chk("latch_shape", lat_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
